// File: rtl/rx_uart_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rx_uart_param : tick-enabled oversampling UART receiver with parity,       |
// |                 framing/break handling and start-glitch rejection.         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module rx_uart_param #(
  parameter int NB_DATA      = 8,
  parameter int N_OVERSAMPLE = 16,
  parameter int NB_COUNT     = 4,
  parameter int PARITY_MODE  = 0,
  parameter int N_STOP       = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done_tick,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam logic [NB_COUNT-1:0] c_half_bit  = NB_COUNT'(N_OVERSAMPLE / 2 - 1);
  localparam logic [NB_COUNT-1:0] c_full_bit  = NB_COUNT'(N_OVERSAMPLE - 1);
  localparam logic [3:0]          c_last_bit  = 4'(NB_DATA - 1);
  localparam logic                c_last_stop = 1'(N_STOP - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  logic               r_rx_meta, r_rx_s;
  state_t             r_state, w_state;
  logic [NB_COUNT-1:0] r_cnt, w_cnt;
  logic [3:0]         r_bit_idx, w_bit_idx;
  logic [NB_DATA-1:0] r_shift, w_shift;
  logic               r_stop_idx, w_stop_idx;
  logic               r_perr_acc, w_perr_acc;
  logic               r_ferr_acc, w_ferr_acc;
  logic               r_armed, w_armed;
  logic [NB_DATA-1:0] r_data, w_data;
  logic               r_parity_err, w_parity_err;
  logic               r_frame_err, w_frame_err;
  logic               r_done, w_done;
  logic               w_ferr_now;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_stop_idx   <= 1'b0;
      r_perr_acc   <= 1'b0;
      r_ferr_acc   <= 1'b0;
      r_armed      <= 1'b1;
      r_data       <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_bit_idx    <= w_bit_idx;
      r_shift      <= w_shift;
      r_stop_idx   <= w_stop_idx;
      r_perr_acc   <= w_perr_acc;
      r_ferr_acc   <= w_ferr_acc;
      r_armed      <= w_armed;
      r_data       <= w_data;
      r_parity_err <= w_parity_err;
      r_frame_err  <= w_frame_err;
      r_done       <= w_done;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_bit_idx    = r_bit_idx;
    w_shift      = r_shift;
    w_stop_idx   = r_stop_idx;
    w_perr_acc   = r_perr_acc;
    w_ferr_acc   = r_ferr_acc;
    w_armed      = r_armed;
    w_data       = r_data;
    w_parity_err = r_parity_err;
    w_frame_err  = r_frame_err;
    w_done       = 1'b0;
    w_ferr_now   = r_ferr_acc | ~r_rx_s;

    if (i_tick) begin
      case (r_state)
        ST_IDLE: begin
          // A low line only starts a frame once a high level has re-armed us after a break.
          if (r_rx_s) begin
            w_armed = 1'b1;
          end else if (r_armed) begin
            w_state = ST_START;
            w_cnt   = '0;
          end
        end

        ST_START: begin
          if (r_cnt == c_half_bit) begin
            if (!r_rx_s) begin
              w_state    = ST_DATA;
              w_cnt      = '0;
              w_bit_idx  = '0;
              w_stop_idx = 1'b0;
              w_perr_acc = 1'b0;
              w_ferr_acc = 1'b0;
            end else begin
              w_state = ST_IDLE;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (r_cnt == c_full_bit) begin
            w_cnt   = '0;
            w_shift = {r_rx_s, r_shift[NB_DATA-1:1]};
            if (r_bit_idx == c_last_bit) begin
              w_state = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
            end else begin
              w_bit_idx = r_bit_idx + 1'b1;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end

        ST_PARITY: begin
          if (r_cnt == c_full_bit) begin
            w_cnt      = '0;
            w_state    = ST_STOP;
            w_perr_acc = (PARITY_MODE == 2) ? ~(^r_shift ^ r_rx_s) : (^r_shift ^ r_rx_s);
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (r_cnt == c_full_bit) begin
            w_cnt = '0;
            if (r_stop_idx == c_last_stop) begin
              // Leave mid stop bit so a back-to-back start edge is not missed.
              w_state      = ST_IDLE;
              w_data       = r_shift;
              w_parity_err = r_perr_acc;
              w_frame_err  = w_ferr_now;
              w_done       = 1'b1;
              if (!r_rx_s) begin
                w_armed = 1'b0;
              end
            end else begin
              w_stop_idx = 1'b1;
              w_ferr_acc = w_ferr_now;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end

        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  assign o_data         = r_data;
  assign o_rx_done_tick = r_done;
  assign o_parity_err   = r_parity_err;
  assign o_frame_err    = r_frame_err;
  assign o_busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/rx_uart_param.md
Name: rx_uart_param

Overview:
Parametrised UART receiver. Successor to the fixed 8-bit receiver.
- Runs on the system clock and advances only on an external oversampling tick enable (i_tick).
- Configurable data width, oversampling ratio, parity mode and stop-bit count.
- Reports parity and framing errors, handles break conditions, and rejects start-bit glitches.
- Sits between the baud-rate generator and the RX FIFO / interface logic.

Parameters:
NB_DATA, 8, data bits per frame; supported range 5..9; LSB first on the line.
N_OVERSAMPLE, 16, i_tick pulses per bit period; must be even and >= 8.
NB_COUNT, 4, tick-counter width; 2^NB_COUNT >= N_OVERSAMPLE.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
N_STOP, 1, stop bits per frame; 1 or 2.

Ports:
i_clock  in  1  system clock, rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_tick  in  1  one-cycle oversampling enable; N_OVERSAMPLE pulses per bit.
i_rx  in  1  serial input, idle high, asynchronous to i_clock.
o_data  out  NB_DATA  last received word; held until the next o_rx_done_tick.
o_rx_done_tick  out  1  one-cycle pulse when a frame completes.
o_parity_err  out  1  parity status of the last frame; valid with done, held until the next done.
o_frame_err  out  1  stop-bit status of the last frame; valid with done, held until the next done.
o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; all counters clear.
  - o_data = 0, o_rx_done_tick = 0, both error flags = 0, o_busy = 0.
  - Synchronizer flops reset to 1; the armed flag resets to 1.
  - Reset mid-frame aborts the frame with no done pulse.
- Input synchronizer: i_rx passes through a 2-FF synchronizer (rx_s). Detection latency is 2 clocks.
- All state and counter changes happen only in cycles where i_tick = 1. With no ticks, the block is frozen.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On a tick with rx_s = 1: set armed = 1.
  - On a tick with rx_s = 0 and armed = 1: go to START with tick count = 0.
- START:
  - Count ticks. At count = N_OVERSAMPLE/2 - 1 (mid start bit), check rx_s:
    - rx_s = 0: go to DATA with count = 0 and bit index = 0.
    - rx_s = 1: glitch; return to IDLE with no done pulse and no flag changes.
- DATA:
  - At count = N_OVERSAMPLE - 1 (mid-bit), shift rx_s into the MSB of the shift register (right shift, LSB first) and reset count to 0.
  - After bit index NB_DATA - 1: go to PARITY if PARITY_MODE != 0, else to STOP. Otherwise increment the bit index.
- PARITY:
  - At count = N_OVERSAMPLE - 1, sample the parity bit and go to STOP.
  - Even mode: error if the XOR of data bits and parity bit = 1.
  - Odd mode: error if that XOR = 0.
- STOP:
  - Sample each stop bit at count = N_OVERSAMPLE - 1. Any stop sample = 0 sets frame_err for this frame.
  - After the last stop-bit sample, return to IDLE (mid stop bit, so a back-to-back start edge is caught).
  - On that same clock edge, register o_data, o_parity_err and o_frame_err, and pulse o_rx_done_tick. The outputs are visible in the cycle after the completing tick.
- Break: if the last stop sample = 0, clear armed. The receiver then ignores a low line until rx_s = 1 is seen on a tick. A held-low line therefore produces exactly one done pulse, with frame_err = 1.
- A frame with errors still updates o_data.
- PARITY_MODE = 0: o_parity_err is always 0 and the PARITY state is never entered.
- o_data and the flags are never updated except on the done pulse. o_rx_done_tick is never high two consecutive cycles.

Test Plan:
1. 8N1, N_OVERSAMPLE = 16, i_tick every 4 clocks; send 0xA5, then 0x3C back-to-back.
   -> Two done pulses, each 1 cycle wide. o_data = 0xA5, then 0x3C. Both flags 0. o_busy is low between frames for at most half a bit.
2. PARITY_MODE = 1; send 0x07 with parity bit 1.
   -> o_parity_err = 0.
   Then send 0x07 with parity bit 0.
   -> o_parity_err = 1 and o_data = 0x07.
3. Stop bit driven 0, then line held low for 30 bit times.
   -> Exactly one done with o_frame_err = 1.
   Then release the line high for 1 bit and send 0x55.
   -> o_data = 0x55, o_frame_err = 0.
4. i_rx low pulse lasting 4 ticks.
   -> No done pulse. o_busy returns to 0 at the mid-start check. o_data and flags unchanged.
5. N_STOP = 2, NB_DATA = 7, PARITY_MODE = 2; send 0x2A with correct odd parity and the second stop bit = 0.
   -> o_data = 0x2A, o_parity_err = 0, o_frame_err = 1.
6. Assert i_reset asynchronously (between clock edges) during data bit 3.
   -> All outputs go to 0 immediately with no done pulse. After release, send 0x3C.
   -> o_data = 0x3C, both flags 0.
